// File: rtl/hit_resolver.sv
// Two-player hit resolution: hitbox/hurtbox overlap, health, hit pulses, round end.
// Optional defender hitstun counters are built when HIT_RESOLVER_HITSTUN_EN is defined.
module hit_resolver #(
    parameter logic [6:0] MAX_HEALTH     = 7'd100,
    parameter logic [6:0] DAMAGE         = 7'd10,
    parameter logic [4:0] HITSTUN_FRAMES = 5'd12,
    parameter logic [3:0] ACTIVE_STATE   = 4'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       restart,
    input  logic [3:0] p1_state,
    input  logic [3:0] p2_state,
    input  logic [9:0] p1_hit_x1,
    input  logic [9:0] p1_hit_x2,
    input  logic [9:0] p1_hit_y1,
    input  logic [9:0] p1_hit_y2,
    input  logic [9:0] p2_hit_x1,
    input  logic [9:0] p2_hit_x2,
    input  logic [9:0] p2_hit_y1,
    input  logic [9:0] p2_hit_y2,
    input  logic [9:0] p1_hurt_x1,
    input  logic [9:0] p1_hurt_x2,
    input  logic [9:0] p1_hurt_y1,
    input  logic [9:0] p1_hurt_y2,
    input  logic [9:0] p2_hurt_x1,
    input  logic [9:0] p2_hurt_x2,
    input  logic [9:0] p2_hurt_y1,
    input  logic [9:0] p2_hurt_y2,
    output logic [6:0] p1_health,
    output logic [6:0] p2_health,
    output logic       p1_hit_pulse,
    output logic       p2_hit_pulse,
    output logic       p1_hitstun,
    output logic       p2_hitstun,
    output logic       game_over,
    output logic [1:0] winner
);

    typedef enum logic {StFight, StOver} state_t;

    state_t     r_state, w_state_next;
    logic [6:0] r_p1_health, r_p2_health, w_p1_health_next, w_p2_health_next;
    logic       r_p1_pulse, r_p2_pulse, w_p1_pulse_next, w_p2_pulse_next;
    logic       r_p1_consumed, r_p2_consumed, w_p1_consumed_next, w_p2_consumed_next;
    logic       r_game_over, w_game_over_next;
    logic [1:0] r_winner, w_winner_next;
    logic       w_p1_stunned, w_p2_stunned;
    logic       w_p1_cand, w_p2_cand;

    function automatic logic overlap(input logic [9:0] ax1, input logic [9:0] ax2,
                                     input logic [9:0] ay1, input logic [9:0] ay2,
                                     input logic [9:0] bx1, input logic [9:0] bx2,
                                     input logic [9:0] by1, input logic [9:0] by2);
        return (ax1 <= bx2) && (bx1 <= ax2) && (ay1 <= by2) && (by1 <= ay2);
    endfunction

    function automatic logic [6:0] sat_sub(input logic [6:0] h);
        return (h >= DAMAGE) ? h - DAMAGE : 7'd0;
    endfunction

`ifdef HIT_RESOLVER_HITSTUN_EN
    logic [4:0] r_p1_stun, r_p2_stun, w_p1_stun_next, w_p2_stun_next;
    assign w_p1_stunned = (r_p1_stun != 5'd0);
    assign w_p2_stunned = (r_p2_stun != 5'd0);
`else
    assign w_p1_stunned = 1'b0;
    assign w_p2_stunned = 1'b0;
`endif

    assign w_p1_cand = (p1_state == ACTIVE_STATE) && !r_p1_consumed && !w_p2_stunned &&
                       overlap(p1_hit_x1, p1_hit_x2, p1_hit_y1, p1_hit_y2,
                               p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2);
    assign w_p2_cand = (p2_state == ACTIVE_STATE) && !r_p2_consumed && !w_p1_stunned &&
                       overlap(p2_hit_x1, p2_hit_x2, p2_hit_y1, p2_hit_y2,
                               p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2);

    always_comb begin
        w_state_next       = r_state;
        w_p1_health_next   = r_p1_health;
        w_p2_health_next   = r_p2_health;
        w_p1_pulse_next    = 1'b0;
        w_p2_pulse_next    = 1'b0;
        w_p1_consumed_next = r_p1_consumed;
        w_p2_consumed_next = r_p2_consumed;
        w_game_over_next   = r_game_over;
        w_winner_next      = r_winner;
`ifdef HIT_RESOLVER_HITSTUN_EN
        w_p1_stun_next     = r_p1_stun;
        w_p2_stun_next     = r_p2_stun;
`endif
        unique case (r_state)
            StFight: begin
                if (tick) begin
                    // Both candidates resolve in parallel so a trade hits both players.
                    if (w_p1_cand) begin
                        w_p2_health_next = sat_sub(r_p2_health);
                        w_p2_pulse_next  = 1'b1;
                    end
                    if (w_p2_cand) begin
                        w_p1_health_next = sat_sub(r_p1_health);
                        w_p1_pulse_next  = 1'b1;
                    end
                    if (w_p1_cand)                      w_p1_consumed_next = 1'b1;
                    else if (p1_state != ACTIVE_STATE) w_p1_consumed_next = 1'b0;
                    if (w_p2_cand)                      w_p2_consumed_next = 1'b1;
                    else if (p2_state != ACTIVE_STATE) w_p2_consumed_next = 1'b0;
`ifdef HIT_RESOLVER_HITSTUN_EN
                    if (w_p2_cand)      w_p1_stun_next = HITSTUN_FRAMES;
                    else if (w_p1_stunned) w_p1_stun_next = r_p1_stun - 5'd1;
                    if (w_p1_cand)      w_p2_stun_next = HITSTUN_FRAMES;
                    else if (w_p2_stunned) w_p2_stun_next = r_p2_stun - 5'd1;
`endif
                    if ((w_p1_health_next == 7'd0) || (w_p2_health_next == 7'd0)) begin
                        w_state_next     = StOver;
                        w_game_over_next = 1'b1;
                        // Bit 1 flags P2 as a winner (P1 dead), bit 0 flags P1.
                        w_winner_next    = {w_p1_health_next == 7'd0,
                                            w_p2_health_next == 7'd0};
                    end
                end
            end
            StOver: begin
                if (restart) begin
                    w_state_next       = StFight;
                    w_p1_health_next   = MAX_HEALTH;
                    w_p2_health_next   = MAX_HEALTH;
                    w_p1_consumed_next = 1'b0;
                    w_p2_consumed_next = 1'b0;
                    w_game_over_next   = 1'b0;
                    w_winner_next      = 2'b00;
`ifdef HIT_RESOLVER_HITSTUN_EN
                    w_p1_stun_next     = 5'd0;
                    w_p2_stun_next     = 5'd0;
`endif
                end
            end
            default: w_state_next = StFight;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= StFight;
            r_p1_health   <= MAX_HEALTH;
            r_p2_health   <= MAX_HEALTH;
            r_p1_pulse    <= 1'b0;
            r_p2_pulse    <= 1'b0;
            r_p1_consumed <= 1'b0;
            r_p2_consumed <= 1'b0;
            r_game_over   <= 1'b0;
            r_winner      <= 2'b00;
        end else begin
            r_state       <= w_state_next;
            r_p1_health   <= w_p1_health_next;
            r_p2_health   <= w_p2_health_next;
            r_p1_pulse    <= w_p1_pulse_next;
            r_p2_pulse    <= w_p2_pulse_next;
            r_p1_consumed <= w_p1_consumed_next;
            r_p2_consumed <= w_p2_consumed_next;
            r_game_over   <= w_game_over_next;
            r_winner      <= w_winner_next;
        end
    end

`ifdef HIT_RESOLVER_HITSTUN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p1_stun <= 5'd0;
            r_p2_stun <= 5'd0;
        end else begin
            r_p1_stun <= w_p1_stun_next;
            r_p2_stun <= w_p2_stun_next;
        end
    end
`endif

    assign p1_health    = r_p1_health;
    assign p2_health    = r_p2_health;
    assign p1_hit_pulse = r_p1_pulse;
    assign p2_hit_pulse = r_p2_pulse;
    assign p1_hitstun   = w_p1_stunned;
    assign p2_hitstun   = w_p2_stunned;
    assign game_over    = r_game_over;
    assign winner       = r_winner;

endmodule

// File: tb/tb_hit_resolver.sv
// Scoreboard bench for hit_resolver: a default instance plus a low-health instance
// (MAX_HEALTH=15) that exercises saturation; both are checked on every hit pulse.
module tb_hit_resolver;

`ifdef HIT_RESOLVER_HITSTUN_EN
    localparam int GAP = 12;
`else
    localparam int GAP = 1;
`endif

    typedef struct packed {
        logic       p1p;
        logic       p2p;
        logic [6:0] h1;
        logic [6:0] h2;
        logic       go;
        logic [1:0] w;
    } exp_t;

    logic clk = 1'b0;
    logic rst, tick, tick2, restart;
    logic [3:0] p1_state, p2_state;
    logic [9:0] p1_hit_x1, p1_hit_x2, p1_hit_y1, p1_hit_y2;
    logic [9:0] p2_hit_x1, p2_hit_x2, p2_hit_y1, p2_hit_y2;
    logic [9:0] p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2;
    logic [9:0] p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2;

    logic [6:0] a_h1, a_h2, b_h1, b_h2;
    logic       a_p1p, a_p2p, b_p1p, b_p2p;
    logic       a_s1, a_s2, b_s1, b_s2;
    logic       a_go, b_go;
    logic [1:0] a_w, b_w;

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;
    int   n_vec = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    hit_resolver u_dut (
        .clk(clk), .rst(rst), .tick(tick), .restart(restart),
        .p1_state(p1_state), .p2_state(p2_state),
        .p1_hit_x1(p1_hit_x1), .p1_hit_x2(p1_hit_x2),
        .p1_hit_y1(p1_hit_y1), .p1_hit_y2(p1_hit_y2),
        .p2_hit_x1(p2_hit_x1), .p2_hit_x2(p2_hit_x2),
        .p2_hit_y1(p2_hit_y1), .p2_hit_y2(p2_hit_y2),
        .p1_hurt_x1(p1_hurt_x1), .p1_hurt_x2(p1_hurt_x2),
        .p1_hurt_y1(p1_hurt_y1), .p1_hurt_y2(p1_hurt_y2),
        .p2_hurt_x1(p2_hurt_x1), .p2_hurt_x2(p2_hurt_x2),
        .p2_hurt_y1(p2_hurt_y1), .p2_hurt_y2(p2_hurt_y2),
        .p1_health(a_h1), .p2_health(a_h2),
        .p1_hit_pulse(a_p1p), .p2_hit_pulse(a_p2p),
        .p1_hitstun(a_s1), .p2_hitstun(a_s2),
        .game_over(a_go), .winner(a_w)
    );

    hit_resolver #(.MAX_HEALTH(7'd15)) u_low (
        .clk(clk), .rst(rst), .tick(tick2), .restart(restart),
        .p1_state(p1_state), .p2_state(p2_state),
        .p1_hit_x1(p1_hit_x1), .p1_hit_x2(p1_hit_x2),
        .p1_hit_y1(p1_hit_y1), .p1_hit_y2(p1_hit_y2),
        .p2_hit_x1(p2_hit_x1), .p2_hit_x2(p2_hit_x2),
        .p2_hit_y1(p2_hit_y1), .p2_hit_y2(p2_hit_y2),
        .p1_hurt_x1(p1_hurt_x1), .p1_hurt_x2(p1_hurt_x2),
        .p1_hurt_y1(p1_hurt_y1), .p1_hurt_y2(p1_hurt_y2),
        .p2_hurt_x1(p2_hurt_x1), .p2_hurt_x2(p2_hurt_x2),
        .p2_hurt_y1(p2_hurt_y1), .p2_hurt_y2(p2_hurt_y2),
        .p1_health(b_h1), .p2_health(b_h2),
        .p1_hit_pulse(b_p1p), .p2_hit_pulse(b_p2p),
        .p1_hitstun(b_s1), .p2_hitstun(b_s2),
        .game_over(b_go), .winner(b_w)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic p1p, input logic p2p, input int h1, input int h2,
                                input logic go, input logic [1:0] w);
        exp_t e;
        e.p1p = p1p;
        e.p2p = p2p;
        e.h1  = 7'(h1);
        e.h2  = 7'(h2);
        e.go  = go;
        e.w   = w;
        return e;
    endfunction

    // Monitors: every hit pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && (a_p1p === 1'b1 || a_p2p === 1'b1)) begin
            if (q1.size() == 0) begin
                check("main_unexpected_pulse", {a_p1p, a_p2p}, 0);
            end else begin
                e1 = q1.pop_front();
                check("main_p1_pulse", a_p1p, e1.p1p);
                check("main_p2_pulse", a_p2p, e1.p2p);
                check("main_p1_health", a_h1, e1.h1);
                check("main_p2_health", a_h2, e1.h2);
                check("main_game_over", a_go, e1.go);
                check("main_winner", a_w, e1.w);
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0 && (b_p1p === 1'b1 || b_p2p === 1'b1)) begin
            if (q2.size() == 0) begin
                check("low_unexpected_pulse", {b_p1p, b_p2p}, 0);
            end else begin
                e2 = q2.pop_front();
                check("low_p1_pulse", b_p1p, e2.p1p);
                check("low_p2_pulse", b_p2p, e2.p2p);
                check("low_p1_health", b_h1, e2.h1);
                check("low_p2_health", b_h2, e2.h2);
                check("low_game_over", b_go, e2.go);
                check("low_winner", b_w, e2.w);
            end
        end
    end

    task automatic do_tick(input logic t1, input logic t2);
        tick  = t1;
        tick2 = t2;
        @(posedge clk);
        #1;
        tick  = 1'b0;
        tick2 = 1'b0;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; tick2 = 1'b0; restart = 1'b0;
        p1_state = 4'd0; p2_state = 4'd0;
        p1_hit_x1 = 10'd200; p1_hit_x2 = 10'd250; p1_hit_y1 = 10'd100; p1_hit_y2 = 10'd150;
        p2_hurt_x1 = 10'd250; p2_hurt_x2 = 10'd300; p2_hurt_y1 = 10'd120; p2_hurt_y2 = 10'd200;
        p1_hurt_x1 = 10'd400; p1_hurt_x2 = 10'd450; p1_hurt_y1 = 10'd300; p1_hurt_y2 = 10'd400;
        p2_hit_x1 = 10'd0; p2_hit_x2 = 10'd10; p2_hit_y1 = 10'd0; p2_hit_y2 = 10'd10;
        repeat (2) @(posedge clk);
        #1;
        check("rst_p1_health", a_h1, 100);
        check("rst_p2_health", a_h2, 100);
        check("rst_pulses", {a_p1p, a_p2p}, 0);
        check("rst_hitstun", {a_s1, a_s2}, 0);
        check("rst_game_over", a_go, 0);
        check("rst_winner", a_w, 0);
        check("rst_low_health", {b_h1, b_h2}, {7'd15, 7'd15});
        rst = 1'b0;
        @(posedge clk);
        #1;

        // First landed hit: touching x edge (250) counts as overlap.
        p1_state = 4'd4;
        q1.push_back(mk(1'b0, 1'b1, 100, 90, 1'b0, 2'b00));
        q2.push_back(mk(1'b0, 1'b1, 15, 5, 1'b0, 2'b00));
        do_tick(1'b1, 1'b1);
        check("hit_latency_health", a_h2, 90);
        @(posedge clk);
        #1;
        check("pulse_one_cycle", a_p2p, 0);

        // Held attack must not hit again.
        repeat (4) do_tick(1'b1, 1'b0);
        check("one_hit_per_attack", a_h2, 90);

        // Release then re-attack: second hit; low instance saturates and P1 wins.
        p1_state = 4'd0;
        repeat (GAP) do_tick(1'b1, 1'b1);
        p1_state = 4'd4;
        q1.push_back(mk(1'b0, 1'b1, 100, 80, 1'b0, 2'b00));
        q2.push_back(mk(1'b0, 1'b1, 15, 0, 1'b1, 2'b01));
        do_tick(1'b1, 1'b1);
        check("low_sat_game_over", b_go, 1);
        check("low_sat_winner", b_w, 2'b01);

        // Low instance in OVER ignores ticks even with a fresh attack.
        p1_state = 4'd0;
        do_tick(1'b0, 1'b1);
        p1_state = 4'd4;
        do_tick(1'b0, 1'b1);
        check("low_over_hold_health", b_h2, 0);
        check("low_over_hold_winner", b_w, 2'b01);

`ifdef HIT_RESOLVER_HITSTUN_EN
        p1_state = 4'd0;
        do_tick(1'b1, 1'b0);
        p1_state = 4'd4;
        repeat (2) do_tick(1'b1, 1'b0);
        check("stun_blocks_hit", a_h2, 80);
        check("stun_active", a_s2, 1);
        p1_state = 4'd0;
        repeat (8) do_tick(1'b1, 1'b0);
        check("stun_still_on", a_s2, 1);
        do_tick(1'b1, 1'b0);
        check("stun_expired", a_s2, 0);
`else
        check("stun_tied_low", {a_s1, a_s2}, 0);
`endif

        // Restart is ignored in FIGHT but honoured in OVER.
        p1_state = 4'd0;
        do_restart();
        check("restart_ignored_fight", a_h2, 80);
        check("restart_ignored_go", a_go, 0);
        check("restart_low_health", {b_h1, b_h2}, {7'd15, 7'd15});
        check("restart_low_go", {b_go, b_w}, 0);

        // P2 lands two solo hits to even the score.
        p2_hit_x1 = 10'd450; p2_hit_x2 = 10'd500; p2_hit_y1 = 10'd400; p2_hit_y2 = 10'd420;
        for (int k = 1; k <= 2; k++) begin
            p2_state = 4'd4;
            q1.push_back(mk(1'b1, 1'b0, 100 - 10 * k, 80, 1'b0, 2'b00));
            do_tick(1'b1, 1'b0);
            p2_state = 4'd0;
            repeat (GAP) do_tick(1'b1, 1'b0);
        end

        // Trades down to 10/10, then the double KO.
        for (int i = 1; i <= 8; i++) begin
            p1_state = 4'd4;
            p2_state = 4'd4;
            q1.push_back(mk(1'b1, 1'b1, 80 - 10 * i, 80 - 10 * i, i == 8,
                            (i == 8) ? 2'b11 : 2'b00));
            do_tick(1'b1, 1'b0);
            if (i < 8) begin
                p1_state = 4'd0;
                p2_state = 4'd0;
                repeat (GAP) do_tick(1'b1, 1'b0);
            end
        end
        repeat (3) do_tick(1'b1, 1'b0);
        check("draw_hold_p1", a_h1, 0);
        check("draw_hold_p2", a_h2, 0);
        check("draw_hold_go", a_go, 1);
        check("draw_hold_winner", a_w, 2'b11);

        do_restart();
        check("restart_p1_health", a_h1, 100);
        check("restart_p2_health", a_h2, 100);
        check("restart_go_winner", {a_go, a_w}, 0);

        // Hit after restart, then reset while its pulse is high.
        p2_state = 4'd0;
        p1_state = 4'd4;
        do_tick(1'b1, 1'b0);
        check("pre_rst_pulse", a_p2p, 1);
        check("pre_rst_health", a_h2, 90);
`ifdef HIT_RESOLVER_HITSTUN_EN
        check("pre_rst_stun", a_s2, 1);
`endif
        rst = 1'b1;
        #1;
        check("async_rst_pulse", a_p2p, 0);
        check("async_rst_health", {a_h1, a_h2}, {7'd100, 7'd100});
        check("async_rst_stun", {a_s1, a_s2}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        p1_state = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_pulse", {a_p1p, a_p2p}, 0);
        check("post_rst_stun", {a_s1, a_s2}, 0);
        check("post_rst_health", a_h2, 100);

        repeat (3) @(posedge clk);
        check("main_queue_drained", q1.size(), 0);
        check("low_queue_drained", q2.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
